// File: rtl/half_adder.sv
// Half adder leaf cell: sum and carry of two bits.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic co
);

  assign s  = x ^ y;
  assign co = x & y;

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder built from two half adders, with a registered copy
// of the result for pipelined users.
module full_adder (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry,
  output logic sum_q,
  output logic carry_q
);

  logic s1;
  logic co1;
  logic co2;

  half_adder u_ha0 (
    .x  (a),
    .y  (b),
    .s  (s1),
    .co (co1)
  );

  half_adder u_ha1 (
    .x  (s1),
    .y  (c),
    .s  (sum),
    .co (co2)
  );

  // At most one stage can generate a carry, so OR gives the majority.
  assign carry = co1 | co2;

  // Registered result; reset clears immediately and holds while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum;
      carry_q <= carry;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: directed sweeps plus randomized
// cycles checked against an arithmetic reference (a + b + c).
module tb_full_adder;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic c;
  logic sum;
  logic carry;
  logic sum_q;
  logic carry_q;

  logic clk_run;
  int   tests;
  int   fails;

  full_adder dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .c       (c),
    .sum     (sum),
    .carry   (carry),
    .sum_q   (sum_q),
    .carry_q (carry_q)
  );

  // Gated bench clock so combinational sweeps can run with clk static.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_add(input logic x, input logic y, input logic z);
    int total;
    total = int'(x) + int'(y) + int'(z);
    return 2'(total);
  endfunction

  task automatic apply(input logic [2:0] abc);
    a = abc[2];
    b = abc[1];
    c = abc[0];
  endtask

  initial begin
    logic [2:0]  abc;
    logic [1:0]  exp_q;
    logic        rnd_rst;

    tests   = 0;
    fails   = 0;
    clk_run = 1'b0;
    rst     = 1'b1;
    apply(3'b000);
    #2;

    check("reset_q", {carry_q, sum_q}, 2'b00);

    // Exhaustive combinational sweep, clock stopped, reset held.
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      apply(abc);
      #1;
      check($sformatf("comb_%b", abc), {carry, sum}, ref_add(abc[2], abc[1], abc[0]));
      check($sformatf("comb_q_held_%b", abc), {carry_q, sum_q}, 2'b00);
    end

    // Combinational independence from rst while it toggles.
    for (int i = 0; i < 8; i++) begin
      abc = 3'(7 - i);
      rst = ~rst;
      apply(abc);
      #1;
      check($sformatf("comb_rst_%b", abc), {carry, sum}, ref_add(abc[2], abc[1], abc[0]));
    end

    // Registered path with clock running.
    rst     = 1'b0;
    clk_run = 1'b1;
    @(negedge clk);
    apply(3'b110);
    @(posedge clk); #1;
    check("reg_110", {carry_q, sum_q}, 2'b10);
    @(negedge clk);
    apply(3'b001);
    @(posedge clk); #1;
    check("reg_001", {carry_q, sum_q}, 2'b01);
    @(negedge clk);
    apply(3'b111);
    @(posedge clk); #1;
    check("reg_111", {carry_q, sum_q}, 2'b11);

    // Async reset pulse between edges.
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_q", {carry_q, sum_q}, 2'b00);
    check("async_rst_comb", {carry, sum}, 2'b11);
    @(posedge clk); #1;
    check("rst_hold_q", {carry_q, sum_q}, 2'b00);

    // Reset release: no capture until the next rising edge.
    @(negedge clk);
    apply(3'b100);
    rst = 1'b0;
    #1;
    check("release_pre_edge", {carry_q, sum_q}, 2'b00);
    @(posedge clk); #1;
    check("release_first_cap", {carry_q, sum_q}, 2'b01);

    // Randomized cycles with occasional reset.
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      abc     = 3'($urandom_range(0, 7));
      rnd_rst = ($urandom_range(0, 15) == 0);
      apply(abc);
      rst = rnd_rst;
      #1;
      check("rand_comb", {carry, sum}, ref_add(abc[2], abc[1], abc[0]));
      exp_q = rnd_rst ? 2'b00 : ref_add(abc[2], abc[1], abc[0]);
      @(posedge clk); #1;
      check("rand_q", {carry_q, sum_q}, exp_q);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name:
full_adder

Overview:
- Single-bit full adder: adds operands a, b and carry-in c, producing sum and carry-out.
- Primary outputs are purely combinational, with zero-cycle latency, for use as the leaf cell of ripple-carry adders.
- A registered copy of the result is also provided for pipelined users, clocked by the block's single clock and cleared by asynchronous reset.

Parameters:
- none (fixed 1-bit datapath)

Ports:
clk  input  1  system clock; drives only the registered outputs
rst  input  1  asynchronous, active-high reset; clears the registered outputs
a  input  1  addend bit
b  input  1  addend bit
c  input  1  carry-in bit
sum  output  1  combinational sum, a XOR b XOR c
carry  output  1  combinational carry-out, majority(a,b,c) = (a AND b) OR (c AND (a XOR b))
sum_q  output  1  sum registered on rising clk
carry_q  output  1  carry registered on rising clk

Interface (already decided):
- One clock; reset is asynchronous and active-high.

Behaviour:
- sum and carry are combinational from a, b and c.
  - No clock and no reset dependence.
  - Valid within one delta/propagation after any input change.
  - Unaffected while rst is asserted.
- Truth table, as abc -> sum,carry:
  - 000->0,0
  - 001->1,0
  - 010->1,0
  - 011->0,1
  - 100->1,0
  - 101->0,1
  - 110->0,1
  - 111->1,1
- Arithmetic rule: {carry,sum} == a + b + c as a 2-bit unsigned value, in range 0..3.
- sum_q and carry_q:
  - Capture sum and carry on every rising clk edge; latency 1 cycle.
  - No enable.
  - No handshake; every cycle is valid.
- Reset:
  - rst asserted forces sum_q=0 and carry_q=0 immediately, independent of clk.
  - The registers hold 0 while rst is high.
  - The first capture occurs on the first rising clk after rst deasserts.
  - Reset mid-operation discards the in-flight registered value; the combinational outputs are unaffected.
- No X propagation requirements beyond standard gate semantics.
- No latches; no internal state other than the two output flops.

Decomposition:
- No shared package is needed (no typedefs; widths fixed at 1).
- Natural sub-module: half_adder (inputs x, y; outputs s = x XOR y, co = x AND y).
  - full_adder instantiates two half_adder cells: first on a,b; second on the first stage's s and c.
  - carry = OR of the two co outputs.
  - Output flops live in full_adder.

Test Plan:
- Exhaustive combinational sweep: apply all 8 abc combinations in order 000..111, holding each ≥1 time unit, with no clock toggling. sum/carry must match the truth table above (e.g. 011->0,1; 111->1,1).
- Arithmetic cross-check: for every abc, {carry,sum} must equal a+b+c (e.g. 101 -> 2'b10, 111 -> 2'b11).
- Registered path: with rst low and clk running, apply 110 then 001 on successive cycles. sum_q/carry_q must equal 0,1 one edge after 110 is applied, then 1,0 one edge after 001 is applied.
- Async reset: with sum_q/carry_q = 1,1 (after 111 is captured), pulse rst between clock edges. Both must drop to 0 immediately, with sum/carry still 1,1.
- Reset release: hold abc=100 and deassert rst. sum_q stays 0 until the next rising clk, then becomes 1; carry_q stays 0.
- Combinational independence: toggle rst and hold clk static while sweeping abc. sum/carry must track the truth table throughout.
